// File: rtl/arm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// arm_ctrl_pkg
//
// Shared definitions for the multicycle ARM controller:
//   - 4-bit state encodings of the main FSM (also exported on the debug port)
//   - field widths of the datapath mux selects
//   - opcode constants of the instruction Op field
//   - the packed 15-bit control vector the main FSM decodes into
//   - a helper that tells whether a state owns the memory port
//
// No ports (package).
// ----------------------------------------------------------------------------
package arm_ctrl_pkg;

    // ------------------------------------------------------------------
    // State encodings. These values are visible on the State debug port,
    // so they are fixed here rather than left to the tool.
    // ------------------------------------------------------------------
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_FAULT    = 4'd10;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECUTER = ST_EXECUTER,
        S_EXECUTEI = ST_EXECUTEI,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH,
        S_FAULT    = ST_FAULT
    } state_t;

    // ------------------------------------------------------------------
    // Datapath select field widths.
    // ------------------------------------------------------------------
    localparam int RESULTSRC_W = 2;
    localparam int ALUSRCA_W   = 2;
    localparam int ALUSRCB_W   = 2;

    // ------------------------------------------------------------------
    // Op field values. Op = 2'b11 is undefined and traps to FAULT.
    // ------------------------------------------------------------------
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Bit positions inside the Funct field.
    localparam int FUNCT_I_BIT = 5;
    localparam int FUNCT_L_BIT = 0;

    // ------------------------------------------------------------------
    // Control vector: 8 single-bit enables + three 2-bit selects + Fault
    // = 15 bits. Decoding into one struct keeps every state's default
    // (all zero) explicit in a single assignment.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic                   mem_req;
        logic                   ir_write;
        logic                   next_pc;
        logic                   reg_w;
        logic                   mem_w;
        logic                   branch;
        logic                   alu_op;
        logic                   adr_src;
        logic [RESULTSRC_W-1:0] result_src;
        logic [ALUSRCA_W-1:0]   alu_src_a;
        logic [ALUSRCB_W-1:0]   alu_src_b;
        logic                   fault;
    } ctrl_t;

    // True for the states that hold a memory access open.
    function automatic logic is_mem_req_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage : arm_ctrl_pkg

// File: rtl/memwait_timer.sv
// ----------------------------------------------------------------------------
// memwait_timer
//
// Counts wait cycles of one memory access and flags when the access has been
// stalled for TIMEOUT cycles without the memory answering.
//
// Parameters:
//   TIMEOUT  maximum wait cycles per access; 0 disables expiry
//   CNT_W    counter width; 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, clears the counter
//   clr      in   synchronous clear (new access starting, or memory ready)
//   en       in   a memory access is open this cycle
//   ready    in   memory completes the access this cycle
//   expired  out  TIMEOUT wait cycles elapsed and memory still not ready
// ----------------------------------------------------------------------------
module memwait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic ready,
    output logic expired
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             TO_ON     = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !ready && (cnt_q != CNT_MAX)) begin
            // Saturate so a disabled timeout never wraps into a stale match.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter holds the number of wait cycles already spent, so a match
    // means this is the (TIMEOUT+1)-th cycle of the access. A ready in this
    // same cycle still completes the access.
    assign expired = TO_ON && en && !ready && (cnt_q == TIMEOUT_V);

endmodule : memwait_timer

// File: rtl/mainfsm_ws.sv
// ----------------------------------------------------------------------------
// mainfsm_ws
//
// Main control FSM of the multicycle ARM datapath with memory wait-states.
// Sequences FETCH / DECODE / EXECUTE / MEM / WB, stalls in the memory states
// (FETCH, MEMREAD, MEMWRITE) until MemReady, bounds each stall with a
// timeout, and traps undefined opcodes or timeouts in a sticky FAULT state
// left only through reset.
//
// Parameters:
//   TIMEOUT   maximum wait cycles per memory access (0 = no timeout)
//   CNT_W     wait counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, forces FETCH
//   Op         in   instruction op field
//   Funct      in   funct field (bit 5 = I, bit 0 = L)
//   MemReady   in   memory completes the current access this cycle
//   MemReq     out  memory access in progress
//   IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc
//              out  datapath enables / selects
//   ResultSrc, ALUSrcA, ALUSrcB
//              out  2-bit datapath mux selects
//   Fault      out  high while in FAULT
//   State      out  current state encoding (debug)
//
// Handshake: a memory access is open in every cycle MemReq is high; it
// completes in the cycle MemReady is high while MemReq is high. MemReady
// has no effect in cycles where MemReq is low.
// ----------------------------------------------------------------------------
module mainfsm_ws
    import arm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             Op,
    input  logic [5:0]             Funct,
    input  logic                   MemReady,
    output logic                   MemReq,
    output logic                   IRWrite,
    output logic                   NextPC,
    output logic                   RegW,
    output logic                   MemW,
    output logic                   Branch,
    output logic                   ALUOp,
    output logic                   AdrSrc,
    output logic [RESULTSRC_W-1:0] ResultSrc,
    output logic [ALUSRCA_W-1:0]   ALUSrcA,
    output logic [ALUSRCB_W-1:0]   ALUSrcB,
    output logic                   Fault,
    output logic [3:0]             State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    logic   in_mem;
    logic   entering_mem;
    logic   timer_clr;
    logic   timer_expired;

    // Only I and L steer the sequence; the other funct bits belong to the
    // ALU decoder.
    logic   unused_funct;
    assign unused_funct = ^Funct[4:1];

    // ------------------------------------------------------------------
    // Wait-state timer
    // ------------------------------------------------------------------
    assign in_mem       = is_mem_req_state(state_q);
    // A fresh access starts whenever the next state is a memory state we
    // are not already in; staying in one keeps the running count.
    assign entering_mem = is_mem_req_state(state_d) && (state_d != state_q);
    assign timer_clr    = entering_mem || MemReady;

    memwait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_memwait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (in_mem),
        .ready   (MemReady),
        .expired (timer_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In the memory states MemReady is tested before
    // the timeout, so a late answer still completes the access.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_DP:   state_d = Funct[FUNCT_I_BIT] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            S_MEMADR: begin
                state_d = Funct[FUNCT_L_BIT] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB,
            S_ALUWB,
            S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            // Encodings 11..15 are unreachable; trap them if ever seen.
            default:  state_d = S_FAULT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: depends on the state and, in FETCH only, MemReady.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = 2'b01;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                // Latch the instruction and bump PC only when it arrives.
                ctrl.ir_write   = MemReady;
                ctrl.next_pc    = MemReady;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 2'b01;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
            end
            S_EXECUTER: begin
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_b  = 2'b01;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_w      = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_b  = 2'b01;
            end
            S_MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = 2'b01;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                // Write strobe stays up for the whole wait.
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 2'b10;
                ctrl.alu_src_b  = 2'b01;
                ctrl.result_src = 2'b10;
                ctrl.branch     = 1'b1;
            end
            S_FAULT: begin
                ctrl.fault      = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign MemReq    = ctrl.mem_req;
    assign IRWrite   = ctrl.ir_write;
    assign NextPC    = ctrl.next_pc;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.alu_op;
    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign Fault     = ctrl.fault;
    assign State     = state_q;

endmodule : mainfsm_ws

// File: tb/tb_mainfsm_ws.sv
// ----------------------------------------------------------------------------
// tb_mainfsm_ws
//
// Directed bench for mainfsm_ws. Two instances share all inputs: dut uses
// the default TIMEOUT=15, dut0 uses TIMEOUT=0. Inputs change just after the
// falling edge; outputs are checked 1 time unit later, well before the next
// rising edge.
// ----------------------------------------------------------------------------
module tb_mainfsm_ws;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;

    logic       mem_req, ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic       fault;
    logic [3:0] state;

    logic       z_mem_req, z_ir_write, z_next_pc, z_reg_w, z_mem_w, z_branch, z_alu_op, z_adr_src;
    logic [1:0] z_result_src, z_alu_src_a, z_alu_src_b;
    logic       z_fault;
    logic [3:0] z_state;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    mainfsm_ws #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .MemReq    (mem_req),
        .IRWrite   (ir_write),
        .NextPC    (next_pc),
        .RegW      (reg_w),
        .MemW      (mem_w),
        .Branch    (branch),
        .ALUOp     (alu_op),
        .AdrSrc    (adr_src),
        .ResultSrc (result_src),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .Fault     (fault),
        .State     (state)
    );

    mainfsm_ws #(.TIMEOUT(0), .CNT_W(4)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .MemReq    (z_mem_req),
        .IRWrite   (z_ir_write),
        .NextPC    (z_next_pc),
        .RegW      (z_reg_w),
        .MemW      (z_mem_w),
        .Branch    (z_branch),
        .ALUOp     (z_alu_op),
        .AdrSrc    (z_adr_src),
        .ResultSrc (z_result_src),
        .ALUSrcA   (z_alu_src_a),
        .ALUSrcB   (z_alu_src_b),
        .Fault     (z_fault),
        .State     (z_state)
    );

    // ------------------------------------------------------------------
    // Check and drive tasks
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, apply inputs, let combinational outputs settle.
    task automatic go(input logic rdy, input logic [1:0] op, input logic [5:0] fn);
        @(negedge clk);
        reset    = 1'b0;
        MemReady = rdy;
        Op       = op;
        Funct    = fn;
        #1;
    endtask

    // Assert reset mid-cycle; it is released by the next go().
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_state"}, state, 4'd0);
        chk({tag, "_fault"}, fault, 1'b0);
        chk({tag, "_memreq"}, mem_req, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset    = 1'b1;
        MemReady = 1'b0;
        Op       = 2'b00;
        Funct    = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        #1;

        // Reset values: FETCH decode with MemReady=0.
        chk("rst_state",     state,      4'd0);
        chk("rst_memreq",    mem_req,    1'b1);
        chk("rst_alusrca",   alu_src_a,  2'b01);
        chk("rst_alusrcb",   alu_src_b,  2'b10);
        chk("rst_resultsrc", result_src, 2'b10);
        chk("rst_irwrite",   ir_write,   1'b0);
        chk("rst_nextpc",    next_pc,    1'b0);
        chk("rst_regw",      reg_w,      1'b0);
        chk("rst_memw",      mem_w,      1'b0);
        chk("rst_fault",     fault,      1'b0);

        // ADD register form, MemReady held high: 0,1,6,8,0.
        go(1'b1, 2'b00, 6'b000000);
        chk("add_c1_state",   state,    4'd0);
        chk("add_c1_irwrite", ir_write, 1'b1);
        chk("add_c1_nextpc",  next_pc,  1'b1);
        chk("add_c1_regw",    reg_w,    1'b0);
        go(1'b1, 2'b00, 6'b000000);
        chk("add_c2_state",   state,    4'd1);
        chk("add_c2_irwrite", ir_write, 1'b0);
        chk("add_c2_regw",    reg_w,    1'b0);
        go(1'b1, 2'b00, 6'b000000);
        chk("add_c3_state",   state,    4'd6);
        chk("add_c3_aluop",   alu_op,   1'b1);
        chk("add_c3_regw",    reg_w,    1'b0);
        go(1'b1, 2'b00, 6'b000000);
        chk("add_c4_state",   state,    4'd8);
        chk("add_c4_regw",    reg_w,    1'b1);

        // LDR with 3 data wait cycles: 8 cycles total.
        go(1'b1, 2'b01, 6'b000001);
        chk("ldr_c1_state",   state,    4'd0);
        chk("ldr_c1_regw",    reg_w,    1'b0);
        go(1'b1, 2'b01, 6'b000001);
        chk("ldr_c2_state",   state,    4'd1);
        go(1'b1, 2'b01, 6'b000001);
        chk("ldr_c3_state",   state,    4'd2);
        chk("ldr_c3_alusrcb", alu_src_b, 2'b01);
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 2'b01, 6'b000001);
            chk($sformatf("ldr_wait%0d_state", i),  state,   4'd3);
            chk($sformatf("ldr_wait%0d_memreq", i), mem_req, 1'b1);
            chk($sformatf("ldr_wait%0d_adrsrc", i), adr_src, 1'b1);
        end
        go(1'b1, 2'b01, 6'b000001);
        chk("ldr_c7_state",   state,      4'd3);
        chk("ldr_c7_memreq",  mem_req,    1'b1);
        go(1'b1, 2'b01, 6'b000001);
        chk("ldr_c8_state",   state,      4'd4);
        chk("ldr_c8_result",  result_src, 2'b01);
        chk("ldr_c8_regw",    reg_w,      1'b1);
        chk("ldr_c8_memreq",  mem_req,    1'b0);

        // STR, MemReady low for 15 cycles then high: completes.
        go(1'b1, 2'b01, 6'b000000);
        chk("str15_c1_state", state, 4'd0);
        go(1'b1, 2'b01, 6'b000000);
        chk("str15_c2_state", state, 4'd1);
        go(1'b1, 2'b01, 6'b000000);
        chk("str15_c3_state", state, 4'd2);
        for (int i = 0; i < 15; i++) begin
            go(1'b0, 2'b01, 6'b000000);
            chk($sformatf("str15_wait%0d_state", i), state, 4'd5);
            chk($sformatf("str15_wait%0d_memw", i),  mem_w, 1'b1);
        end
        go(1'b1, 2'b01, 6'b000000);
        chk("str15_done_state", state, 4'd5);
        chk("str15_done_memw",  mem_w, 1'b1);

        // STR, MemReady low for 16 cycles: FAULT, held until reset.
        go(1'b1, 2'b01, 6'b000000);
        chk("str16_c1_state", state, 4'd0);
        chk("str16_c1_fault", fault, 1'b0);
        go(1'b1, 2'b01, 6'b000000);
        chk("str16_c2_state", state, 4'd1);
        go(1'b1, 2'b01, 6'b000000);
        chk("str16_c3_state", state, 4'd2);
        for (int i = 0; i < 16; i++) begin
            go(1'b0, 2'b01, 6'b000000);
            chk($sformatf("str16_wait%0d_state", i), state, 4'd5);
        end
        go(1'b0, 2'b01, 6'b000000);
        chk("str16_to_state",  state,   4'd10);
        chk("str16_to_fault",  fault,   1'b1);
        chk("str16_to_memw",   mem_w,   1'b0);
        chk("str16_to_memreq", mem_req, 1'b0);
        go(1'b1, 2'b00, 6'b000000);
        chk("fault_hold1_state", state, 4'd10);
        go(1'b0, 2'b01, 6'b000001);
        chk("fault_hold2_state", state, 4'd10);
        chk("fault_hold2_fault", fault, 1'b1);
        reset_pulse("str16_rst");

        // Undefined opcode Op=11 traps in DECODE.
        go(1'b1, 2'b11, 6'b000000);
        chk("und_c1_state", state, 4'd0);
        go(1'b1, 2'b11, 6'b000000);
        chk("und_c2_state", state, 4'd1);
        go(1'b1, 2'b11, 6'b000000);
        chk("und_c3_state",   state,     4'd10);
        chk("und_c3_fault",   fault,     1'b1);
        chk("und_c3_regw",    reg_w,     1'b0);
        chk("und_c3_irwrite", ir_write,  1'b0);
        chk("und_c3_memreq",  mem_req,   1'b0);
        chk("und_c3_alusrca", alu_src_a, 2'b00);
        reset_pulse("und_rst");

        // Branch: 0,1,9,0.
        go(1'b1, 2'b10, 6'b000000);
        chk("b_c1_state",  state,  4'd0);
        chk("b_c1_branch", branch, 1'b0);
        go(1'b1, 2'b10, 6'b000000);
        chk("b_c2_state",  state,  4'd1);
        chk("b_c2_branch", branch, 1'b0);
        go(1'b1, 2'b10, 6'b000000);
        chk("b_c3_state",   state,      4'd9);
        chk("b_c3_branch",  branch,     1'b1);
        chk("b_c3_alusrca", alu_src_a,  2'b10);
        chk("b_c3_alusrcb", alu_src_b,  2'b01);
        chk("b_c3_result",  result_src, 2'b10);

        // 40-cycle FETCH stall: TIMEOUT=0 never faults, TIMEOUT=15 does.
        for (int i = 0; i < 40; i++) begin
            go(1'b0, 2'b10, 6'b000000);
            chk($sformatf("stall%0d_z_state", i), z_state, 4'd0);
            chk($sformatf("stall%0d_z_fault", i), z_fault, 1'b0);
            chk($sformatf("stall%0d_z_branch", i), z_branch, 1'b0);
        end
        chk("stall_dut_state", state, 4'd10);
        chk("stall_dut_fault", fault, 1'b1);
        go(1'b1, 2'b10, 6'b000000);
        chk("stall_end_z_state",   z_state,    4'd0);
        chk("stall_end_z_irwrite", z_ir_write, 1'b1);
        go(1'b1, 2'b10, 6'b000000);
        chk("stall_dec_z_state",   z_state,    4'd1);
        reset_pulse("stall_rst");

        // Async reset in the middle of a MEMWRITE wait.
        go(1'b1, 2'b01, 6'b000000);
        chk("arst_c1_state", state, 4'd0);
        go(1'b1, 2'b01, 6'b000000);
        chk("arst_c2_state", state, 4'd1);
        go(1'b1, 2'b01, 6'b000000);
        chk("arst_c3_state", state, 4'd2);
        for (int i = 0; i < 5; i++) begin
            go(1'b0, 2'b01, 6'b000000);
            chk($sformatf("arst_wait%0d_memw", i), mem_w, 1'b1);
        end
        go(1'b0, 2'b01, 6'b000000);
        chk("arst_pre_memw", mem_w, 1'b1);
        reset_pulse("arst");
        chk("arst_memw",    mem_w,    1'b0);
        chk("arst_irwrite", ir_write, 1'b0);
        chk("arst_regw",    reg_w,    1'b0);
        // Counter must be cleared: a full 15-cycle FETCH stall still succeeds.
        for (int i = 0; i < 15; i++) begin
            go(1'b0, 2'b01, 6'b000000);
            chk($sformatf("arst_fetch%0d_state", i), state, 4'd0);
        end
        go(1'b1, 2'b01, 6'b000000);
        chk("arst_fetch_done_state",   state,    4'd0);
        chk("arst_fetch_done_irwrite", ir_write, 1'b1);
        go(1'b1, 2'b01, 6'b000000);
        chk("arst_decode_state", state, 4'd1);
        chk("arst_decode_fault", fault, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mainfsm_ws
